// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the parametrised RAM.
// Used by the datapath, the clear sequencer and the bench.
package mem_pkg;

    localparam int DW_DEF    = 12;
    localparam int DEPTH_DEF = 101;
    localparam int AW_DEF    = 11;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } mem_state_t;

    // Array index width; at least one bit even for a single-word array.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_clr_fsm.sv
// Zero-fill sequencer: walks every word after reset or Clear,
// then releases the array to the user port via Ready.
module mem_clr_fsm
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int IW    = idx_w(DEPTH_DEF)
) (
    input  logic          MCLK,
    input  logic          MRST_N,
    input  logic          Clear,
    output logic          Ready,
    output logic          ClrWe,
    output logic [IW-1:0] ClrAddr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge MCLK or negedge MRST_N) begin
        if (!MRST_N) begin
            state_q <= ST_CLR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLR: begin
                if (Clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (Clear) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLR;
                cnt_d   = '0;
            end
        endcase
    end

    assign Ready   = (state_q == ST_RUN);
    assign ClrWe   = (state_q == ST_CLR);
    assign ClrAddr = cnt_q[IW-1:0];

endmodule

// File: rtl/param_memory.sv
// Simple-dual-port RAM with zero-fill on reset/Clear, selectable
// read-during-write policy, optional output register, range check.
module param_memory
    import mem_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = AW_DEF,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic          MCLK,
    input  logic          MRST_N,
    input  logic          Clear,
    input  logic          WriteEn,
    input  logic [AW-1:0] WAddress,
    input  logic [DW-1:0] InData,
    input  logic          ReadEn,
    input  logic [AW-1:0] RAddress,
    output logic [DW-1:0] OutData,
    output logic          ReadValid,
    output logic          Ready,
    output logic          AddrErr
);

    localparam int          IW    = idx_w(DEPTH);
    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [IW-1:0] clr_addr;
    logic          w_inr, r_inr;
    logic          wr_ok, rd_ok, bypass;
    logic          mem_we;
    logic [IW-1:0] mem_wa, rd_idx;
    logic [DW-1:0] mem_wd, rd_word;

    mem_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_clr (
        .MCLK    (MCLK),
        .MRST_N  (MRST_N),
        .Clear   (Clear),
        .Ready   (Ready),
        .ClrWe   (clr_we),
        .ClrAddr (clr_addr)
    );

    assign w_inr  = ({1'b0, WAddress} < LIMIT);
    assign r_inr  = ({1'b0, RAddress} < LIMIT);
    assign wr_ok  = Ready & WriteEn & w_inr;
    // A read issued alongside Clear is part of the flushed pipeline.
    assign rd_ok  = Ready & ReadEn & ~Clear;
    assign bypass = (RD_MODE == 1) && wr_ok && (WAddress == RAddress);

    assign mem_we = clr_we | wr_ok;
    assign mem_wa = clr_we ? clr_addr : WAddress[IW-1:0];
    assign mem_wd = clr_we ? '0 : InData;
    assign rd_idx = RAddress[IW-1:0];

    always_ff @(posedge MCLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        rd_word = '0;
        if (r_inr) begin
            rd_word = mem[rd_idx];
        end
        if (bypass) begin
            rd_word = InData;
        end
    end

    always_ff @(posedge MCLK or negedge MRST_N) begin
        if (!MRST_N) begin
            AddrErr <= 1'b0;
        end else begin
            AddrErr <= Ready & ((WriteEn & ~w_inr) | (ReadEn & ~r_inr));
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic          s1_v;
        logic [DW-1:0] s1_d;

        always_ff @(posedge MCLK or negedge MRST_N) begin
            if (!MRST_N) begin
                s1_v      <= 1'b0;
                s1_d      <= '0;
                OutData   <= '0;
                ReadValid <= 1'b0;
            end else begin
                s1_v      <= rd_ok;
                ReadValid <= s1_v & ~Clear;
                if (rd_ok) begin
                    s1_d <= rd_word;
                end
                if (s1_v & ~Clear) begin
                    OutData <= s1_d;
                end
            end
        end
    end else begin : g_dir
        always_ff @(posedge MCLK or negedge MRST_N) begin
            if (!MRST_N) begin
                OutData   <= '0;
                ReadValid <= 1'b0;
            end else begin
                ReadValid <= rd_ok;
                if (rd_ok) begin
                    OutData <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// Bench: two RAM configurations on shared stimulus, checked per cycle
// against an array/latency model of the memory.
module tb_param_memory;
    import mem_pkg::*;

    localparam int DW    = DW_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int AW    = AW_DEF;

    logic          MCLK;
    logic          MRST_N;
    logic          Clear;
    logic          WriteEn;
    logic [AW-1:0] WAddress;
    logic [DW-1:0] InData;
    logic          ReadEn;
    logic [AW-1:0] RAddress;

    logic [DW-1:0] out0, out1;
    logic          rv0, rv1, rdy0, rdy1, err0, err1;

    int n_cmp;
    int n_bad;

    // Reference model state
    int m_mem [DEPTH];
    int clr_left;
    int e_out0, e_out1;
    bit e_rv0, e_rv1, e_rdy, e_err;
    bit p_v;
    int p_d;

    param_memory #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .RD_MODE(0), .OUT_REG(0)
    ) u0 (
        .MCLK(MCLK), .MRST_N(MRST_N), .Clear(Clear),
        .WriteEn(WriteEn), .WAddress(WAddress), .InData(InData),
        .ReadEn(ReadEn), .RAddress(RAddress),
        .OutData(out0), .ReadValid(rv0), .Ready(rdy0), .AddrErr(err0)
    );

    param_memory #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .RD_MODE(1), .OUT_REG(1)
    ) u1 (
        .MCLK(MCLK), .MRST_N(MRST_N), .Clear(Clear),
        .WriteEn(WriteEn), .WAddress(WAddress), .InData(InData),
        .ReadEn(ReadEn), .RAddress(RAddress),
        .OutData(out1), .ReadValid(rv1), .Ready(rdy1), .AddrErr(err1)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready0", {31'd0, rdy0}, {31'd0, e_rdy});
        chk("ready1", {31'd0, rdy1}, {31'd0, e_rdy});
        chk("rvalid0", {31'd0, rv0}, {31'd0, e_rv0});
        chk("rvalid1", {31'd0, rv1}, {31'd0, e_rv1});
        chk("outdata0", {20'd0, out0}, e_out0);
        chk("outdata1", {20'd0, out1}, e_out1);
        chk("addrerr0", {31'd0, err0}, {31'd0, e_err});
        chk("addrerr1", {31'd0, err1}, {31'd0, e_err});
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        clr_left = DEPTH;
        e_out0 = 0;
        e_out1 = 0;
        e_rv0 = 0;
        e_rv1 = 0;
        e_rdy = 0;
        e_err = 0;
        p_v = 0;
        p_d = 0;
    endtask

    // One clock edge of the memory as seen from its contract.
    task automatic model_edge(input bit w, input int wa, input int wd,
                              input bit r, input int ra, input bit c);
        int rv_old;
        int rv_new;
        bit acc;
        rv_old = 0;
        rv_new = 0;
        acc = 0;
        e_err = 0;
        if (clr_left == 0) begin
            rv_old = (ra < DEPTH) ? m_mem[ra] : 0;
            rv_new = (w && wa == ra && ra < DEPTH) ? wd : rv_old;
            e_err = (w && wa >= DEPTH) || (r && ra >= DEPTH);
            if (w && wa < DEPTH) m_mem[wa] = wd;
            acc = r && !c;
        end
        e_rv0 = acc;
        if (acc) e_out0 = rv_old;
        e_rv1 = p_v && !c;
        if (e_rv1) e_out1 = p_d;
        p_v = acc;
        p_d = rv_new;
        if (c) begin
            clr_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = 0;
        end else if (clr_left > 0) begin
            clr_left--;
        end
        e_rdy = (clr_left == 0);
    endtask

    task automatic step(input bit w, input int wa, input int wd,
                        input bit r, input int ra, input bit c);
        WriteEn  = w;
        WAddress = wa[AW-1:0];
        InData   = wd[DW-1:0];
        ReadEn   = r;
        RAddress = ra[AW-1:0];
        Clear    = c;
        @(posedge MCLK);
        model_edge(w, wa, wd & 32'hFFF, r, ra, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        MRST_N = 1'b0;
        Clear = 1'b0;
        WriteEn = 1'b0;
        WAddress = '0;
        InData = '0;
        ReadEn = 1'b0;
        RAddress = '0;
        model_reset();
        repeat (3) @(posedge MCLK);
        #1;
        check_all();
        MRST_N = 1'b1;

        // Zero-fill after reset, then sweep every address
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 1, a, 0);
        idle(2);

        // Basic write/read and neighbour
        step(1, 5, 'hABC, 0, 0, 0);
        step(0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 1, 6, 0);
        idle(2);

        // Same-address write and read in one cycle
        step(1, 7, 'h055, 0, 0, 0);
        step(1, 7, 'h123, 1, 7, 0);
        step(0, 0, 0, 1, 7, 0);
        idle(2);

        // Out-of-range accesses
        step(1, 101, 'hFFF, 0, 0, 0);
        step(0, 0, 0, 1, 120, 0);
        step(1, 130, 'h777, 1, 127, 0);
        step(0, 0, 0, 1, 100, 0);
        step(1, 2047, 'h001, 1, 0, 0);
        idle(2);

        // Clear with a read in flight and a read during zero-fill
        for (int a = 0; a < 4; a++) step(1, a, 'h111, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 2, 0);
        step(1, 3, 'h222, 0, 0, 0);
        idle(DEPTH);
        for (int a = 0; a < 4; a++) step(0, 0, 0, 1, a, 0);
        idle(2);

        // Randomised traffic, biased toward collisions and range edges
        for (int i = 0; i < 600; i++) begin
            int wa;
            int ra;
            if ($urandom_range(0, 1) == 0) begin
                wa = $urandom_range(0, 7);
                ra = $urandom_range(0, 7);
            end else begin
                wa = $urandom_range(95, 130);
                ra = $urandom_range(0, 130);
            end
            step($urandom_range(0, 1) == 1, wa, $urandom & 'hFFF,
                 $urandom_range(0, 1) == 1, ra,
                 $urandom_range(0, 199) == 0);
        end
        idle(DEPTH + 2);

        // Asynchronous reset with a read in flight
        step(1, 9, 'h3C3, 0, 0, 0);
        step(0, 0, 0, 1, 9, 0);
        #3;
        MRST_N = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        MRST_N = 1'b1;
        idle(DEPTH + 2);
        step(0, 0, 0, 1, 9, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
